// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART receive sequencer:
//               FSM state encoding, oversampling constants, and a clog2
//               helper for sizing counters from parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int OVERSAMPLE = 16;  // ticks per bit time
  localparam int MID_SAMPLE = 7;   // last tick before mid start bit

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_ctrl_baud.sv
`default_nettype none
// ============================================================================
// Module      : baud_tick_gen
// Description : Free-running oversample tick divider. Asserts tick for one
//               clk every DVSR clk cycles; never restarted by line activity.
// Ports       : clk   - system clock
//               reset - synchronous active-high reset
//               tick  - one-cycle oversample strobe
// Revision    : 1.0 - initial release
// ============================================================================
module baud_tick_gen #(
  parameter int DVSR   = 163,
  parameter int DVSR_W = 8
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam logic [DVSR_W-1:0] c_TERM = DVSR_W'(DVSR - 1);

  logic [DVSR_W-1:0] r_cnt;
  logic              w_term;

  assign w_term = (r_cnt == c_TERM);
  assign tick   = w_term;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_term) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ctrl
// Description : UART receive sequencer. Synchronises rx, detects the start
//               falling edge, samples mid-bit at 16x oversampling and
//               delivers each word with a one-cycle done strobe and a
//               framing-error flag.
// Ports       : clk          - system clock (rising edge)
//               reset        - synchronous active-high reset
//               rx           - asynchronous serial input, idle high
//               dout         - last received word, LSB first on the line
//               rx_done_tick - one-cycle pulse, dout/frame_err new this cycle
//               frame_err    - stop bit sampled low for the latest word
//               busy         - receiver not idle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 163,
  parameter int DVSR_W  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            busy
);

  // s must reach both the last data tick and the last stop tick.
  localparam int S_W = clog2((SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE);
  localparam int N_W = clog2(DBIT);

  localparam logic [S_W-1:0] c_MID       = S_W'(MID_SAMPLE);
  localparam logic [S_W-1:0] c_BIT_LAST  = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] c_STOP_LAST = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] c_N_LAST    = N_W'(DBIT - 1);

  logic            w_tick;
  logic            r_rx_meta;
  logic            r_rx_s;
  logic            r_rx_prev;
  logic            w_fall;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [S_W-1:0]  r_s;
  logic [S_W-1:0]  w_s_nxt;
  logic [N_W-1:0]  r_n;
  logic [N_W-1:0]  w_n_nxt;
  logic [DBIT-1:0] r_b;
  logic [DBIT-1:0] w_b_nxt;

  logic            w_frame_end;
  logic            w_busy;
  logic [DBIT-1:0] r_dout;
  logic            r_done;
  logic            r_ferr;

  baud_tick_gen #(
    .DVSR   (DVSR),
    .DVSR_W (DVSR_W)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  // Synchroniser and edge history reset to the idle line level so reset
  // release never looks like a start edge. The history flop runs every
  // cycle regardless of state, which lets back-to-back frames be caught.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
    end
  end

  assign w_fall = r_rx_prev & ~r_rx_s;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_n     <= w_n_nxt;
      r_b     <= w_b_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_n_nxt     = r_n;
    w_b_nxt     = r_b;
    case (r_state)
      IDLE: begin
        // Ticks are ignored here, so an edge coinciding with a tick wins.
        if (w_fall) begin
          w_state_nxt = START;
          w_s_nxt     = '0;
        end
      end
      START: begin
        if (w_tick) begin
          if (r_s == c_MID) begin
            if (!r_rx_s) begin
              w_state_nxt = DATA;
              w_s_nxt     = '0;
              w_n_nxt     = '0;
            end else begin
              w_state_nxt = IDLE;  // glitch: line back high at mid start bit
            end
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_s == c_BIT_LAST) begin
            w_s_nxt = '0;
            w_b_nxt = {r_rx_s, r_b[DBIT-1:1]};
            if (r_n == c_N_LAST) begin
              w_state_nxt = STOP;
            end else begin
              w_n_nxt = r_n + 1'b1;
            end
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_s == c_STOP_LAST) begin
            w_state_nxt = IDLE;
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    w_busy      = (r_state != IDLE);
    w_frame_end = (r_state == STOP) && w_tick && (r_s == c_STOP_LAST);
  end

  // Word, error flag and strobe all update on the edge that leaves STOP,
  // so busy drops in the same cycle the strobe is seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout <= '0;
      r_done <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_done <= w_frame_end;
      if (w_frame_end) begin
        r_dout <= r_b;
        r_ferr <= ~r_rx_s;
      end
    end
  end

  assign dout         = r_dout;
  assign rx_done_tick = r_done;
  assign frame_err    = r_ferr;
  assign busy         = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_ctrl
// Description : Self-checking bench for uart_rx_ctrl with DVSR=4, DBIT=8,
//               SB_TICK=16 (64 clk per bit). Table-driven frames plus
//               directed back-to-back, glitch, break and mid-frame reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

  localparam int BIT_CLK   = 64;
  localparam int FRAME_CLK = 10 * BIT_CLK;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  uart_rx_ctrl #(
    .DBIT    (8),
    .SB_TICK (16),
    .DVSR    (4),
    .DVSR_W  (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: records every done pulse sampled on the falling edge.
  int         done_cnt    = 0;
  int         cyc         = 0;
  int         busy_cycles = 0;
  logic       busy_prev   = 1'b0;
  logic [7:0] hist_dout [32];
  logic       hist_ferr [32];
  int         hist_cyc  [32];
  logic       cap_busy_now  = 1'b1;
  logic       cap_busy_prev = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (busy) busy_cycles = busy_cycles + 1;
    if (rx_done_tick) begin
      hist_dout[done_cnt & 31] = dout;
      hist_ferr[done_cnt & 31] = frame_err;
      hist_cyc[done_cnt & 31]  = cyc;
      cap_busy_now  = busy;
      cap_busy_prev = busy_prev;
      done_cnt = done_cnt + 1;
    end
    busy_prev = busy;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks = checks + 1;
    if (act < lo || act > hi) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  task automatic hold_low(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx = 1'b0;
    end
  endtask

  // Drives start, 8 data bits LSB first and the stop bit. If rst_at >= 0,
  // reset is pulsed for one clk at that cycle of the frame and the cleared
  // outputs are checked on the following cycle.
  task automatic drive_frame(input logic [7:0] d, input logic stop_bit, input int rst_at);
    for (int c = 0; c < FRAME_CLK; c++) begin
      int bi;
      @(negedge clk);
      if (rst_at >= 0 && c == rst_at + 1) begin
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_dout", {24'd0, dout}, 32'd0);
        chk("rst_done", {31'd0, rx_done_tick}, 32'd0);
      end
      bi = c / BIT_CLK;
      if (bi == 0)      rx = 1'b0;
      else if (bi == 9) rx = stop_bit;
      else              rx = d[bi-1];
      reset = (c == rst_at);
    end
    reset = 1'b0;
  endtask

  task automatic chk_last(input string name, input int d0, input int nth,
                          input logic [7:0] exp_d, input logic exp_f);
    chk({name, "_dout"}, {24'd0, hist_dout[(d0 + nth) & 31]}, {24'd0, exp_d});
    chk({name, "_ferr"}, {31'd0, hist_ferr[(d0 + nth) & 31]}, {31'd0, exp_f});
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         idle_before;
    logic [7:0] exp_dout;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int d0;
    int b0;
    vecs[0] = '{8'hA5, 1'b1, 10, 8'hA5, 1'b0};
    vecs[1] = '{8'h81, 1'b0, 10, 8'h81, 1'b1};
    vecs[2] = '{8'h00, 1'b1, 64, 8'h00, 1'b0};
    vecs[3] = '{8'h55, 1'b1, 10, 8'h55, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 0,  8'hFF, 1'b0};

    rx    = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_dout", {24'd0, dout}, 32'd0);
    chk("reset_done", {31'd0, rx_done_tick}, 32'd0);
    chk("reset_ferr", {31'd0, frame_err}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;

    // Table-driven single frames
    for (int v = 0; v < 5; v++) begin
      idle(vecs[v].idle_before);
      d0 = done_cnt;
      drive_frame(vecs[v].data, vecs[v].stop_bit, -1);
      chk($sformatf("vec%0d_ndone", v), done_cnt - d0, 1);
      chk_last($sformatf("vec%0d", v), d0, 0, vecs[v].exp_dout, vecs[v].exp_ferr);
      chk($sformatf("vec%0d_busy_at_done", v), {31'd0, cap_busy_now}, 32'd0);
      chk($sformatf("vec%0d_busy_before_done", v), {31'd0, cap_busy_prev}, 32'd1);
    end

    // Back-to-back frames, no gap after the stop bit
    idle(20);
    d0 = done_cnt;
    drive_frame(8'h3C, 1'b1, -1);
    drive_frame(8'hFF, 1'b1, -1);
    chk("b2b_ndone", done_cnt - d0, 2);
    chk_last("b2b_first", d0, 0, 8'h3C, 1'b0);
    chk_last("b2b_second", d0, 1, 8'hFF, 1'b0);
    chk_range("b2b_spacing", hist_cyc[(d0 + 1) & 31] - hist_cyc[d0 & 31], 636, 644);

    // Short low glitch rejected at the mid-start check
    idle(20);
    d0 = done_cnt;
    b0 = busy_cycles;
    hold_low(16);
    idle(100);
    chk("glitch_ndone", done_cnt - d0, 0);
    chk_range("glitch_busy_cycles", busy_cycles - b0, 28, 36);

    // Break: one framing-error word, then no retrigger while low
    idle(20);
    d0 = done_cnt;
    hold_low(2000);
    chk("break_ndone", done_cnt - d0, 1);
    chk_last("break", d0, 0, 8'h00, 1'b1);
    idle(200);
    chk("break_release_ndone", done_cnt - d0, 1);
    drive_frame(8'h42, 1'b1, -1);
    chk("after_break_ndone", done_cnt - d0, 2);
    chk_last("after_break", d0, 1, 8'h42, 1'b0);

    // Reset during data bit 4 of 0x5A; the later low bit 5 starts a
    // misaligned frame that decodes as 0xFD once the line idles high.
    idle(20);
    d0 = done_cnt;
    drive_frame(8'h5A, 1'b1, 5 * BIT_CLK + 25);
    chk("rst_frame_ndone", done_cnt - d0, 0);
    idle(700);
    chk("rst_resync_ndone", done_cnt - d0, 1);
    chk_last("rst_resync", d0, 0, 8'hFD, 1'b0);
    drive_frame(8'h5A, 1'b1, -1);
    chk("rst_after_ndone", done_cnt - d0, 2);
    chk_last("rst_after", d0, 1, 8'h5A, 1'b0);

    idle(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
